// File: rtl/gate_tt_pkg.sv
// Shared types and helpers for the gate truth-table sequencer.
// Optional build macro used by the sequencer: STOP_ON_FAIL_EN.

package gate_tt_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Number of rows in the truth table of an n-input cell
    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/gate_tt_settle_timer.sv
// Settle-window timer: loadable down-counter, expire asserted while the count is zero.
// Loading SETTLE-1 on entry to WAIT keeps the sequencer in WAIT for exactly SETTLE cycles.

module gate_tt_settle_timer
    import gate_tt_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expire
);

    logic [WIDTH-1:0] cnt;

    // Count down to zero after a load, then park at zero
    always_ff @(posedge CK) begin
        if (!RN) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Truth-table sequencer for an N_IN-input standard cell.
// Sweeps every input vector in ascending order, holds each for SETTLE cycles,
// samples ZN and compares against EXP_TT. done pulses one cycle after the DONE state.
// Build macro STOP_ON_FAIL_EN: end the sweep at the first mismatching vector.
//
//   state  | meaning
//   IDLE   | waiting for start, results held
//   WAIT   | vector applied, settle timer running
//   SAMPLE | ZN captured and compared, advance or finish
//   DONE   | sweep complete, pass/done registered on this edge

module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int                          N_IN   = 3,
    parameter int                          SETTLE = 2,
    parameter logic [tt_width(N_IN)-1:0]   EXP_TT = 8'b1111_1110
) (
    input  logic                          CK,
    input  logic                          RN,
    input  logic                          start,
    output logic [N_IN-1:0]               vec_o,
    input  logic                          zn_i,
    output logic                          busy,
    output logic                          done,
    output logic                          pass,
    output logic [N_IN:0]                 err_cnt,
    output logic [N_IN-1:0]               first_fail,
    output logic [tt_width(N_IN)-1:0]     result_tt
);

    localparam int                TW        = $clog2(SETTLE + 1);
    localparam logic [TW-1:0]     TMR_LOAD  = TW'(SETTLE - 1);
    localparam logic [N_IN-1:0]   VEC_ONE   = N_IN'(1);
    localparam logic [N_IN-1:0]   VEC_LAST  = '1;
    localparam logic [N_IN:0]     ERR_ONE   = {{N_IN{1'b0}}, 1'b1};

    state_t state;
    state_t state_nxt;

    logic tmr_load;
    logic tmr_expire;
    logic accept;
    logic do_sample;
    logic advance;
    logic mismatch;
    logic stop_now;

    gate_tt_settle_timer #(
        .WIDTH (TW)
    ) u_settle (
        .CK       (CK),
        .RN       (RN),
        .load     (tmr_load),
        .load_val (TMR_LOAD),
        .expire   (tmr_expire)
    );

    // X or Z on ZN must count as a failure, hence the case inequality
    assign mismatch = (zn_i !== EXP_TT[vec_o]);

`ifdef STOP_ON_FAIL_EN
    assign stop_now = mismatch;
`else
    assign stop_now = 1'b0;
`endif

    assign busy = (state == WAIT) || (state == SAMPLE);

    // State register
    always_ff @(posedge CK) begin
        if (!RN) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state control strobes
    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        accept    = 1'b0;
        do_sample = 1'b0;
        advance   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = WAIT;
                    tmr_load  = 1'b1;
                    accept    = 1'b1;
                end
            end
            WAIT: begin
                if (tmr_expire) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                do_sample = 1'b1;
                if ((vec_o == VEC_LAST) || stop_now) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = WAIT;
                    tmr_load  = 1'b1;
                    advance   = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector drive, result capture, error bookkeeping and the done/pass registers
    always_ff @(posedge CK) begin
        if (!RN) begin
            vec_o      <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
            result_tt  <= '0;
        end else begin
            done <= (state == DONE);
            if (accept) begin
                vec_o      <= '0;
                pass       <= 1'b0;
                err_cnt    <= '0;
                first_fail <= '0;
                result_tt  <= '0;
            end
            if (do_sample) begin
                result_tt[vec_o] <= zn_i;
                if (mismatch) begin
                    err_cnt <= err_cnt + ERR_ONE;
                    if (err_cnt == '0) begin
                        first_fail <= vec_o;
                    end
                end
                if (advance) begin
                    vec_o <= vec_o + VEC_ONE;
                end
            end
            // err_cnt already includes the final sample by the time DONE is reached
            if (state == DONE) begin
                pass <= (err_cnt == '0);
            end
        end
    end

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Self-checking bench for gate_tt_sequencer: a default OR3 instance and an
// N_IN=2 / SETTLE=1 OR2 instance, driven by directed and randomized cell tables.

module tb_gate_tt_sequencer;

    logic CK = 1'b0;
    logic RN;
    logic start0, start1;

    logic [2:0] vec0;
    logic       zn0, busy0, done0, pass0;
    logic [3:0] err0;
    logic [2:0] ff0;
    logic [7:0] tt0;

    logic [1:0] vec1;
    logic       zn1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [1:0] ff1;
    logic [3:0] tt1;

    logic [7:0] cell_tt;
    logic [7:0] xmask;
    logic       sel;

    logic [31:0] o_vec, o_busy, o_done, o_pass, o_err, o_ff, o_tt;

    int tests = 0;
    int fails = 0;

    always #5 CK = ~CK;

    // Cell models: table lookup with optional X injection per vector
    always_comb zn0 = xmask[vec0] ? 1'bx : cell_tt[vec0];
    always_comb zn1 = xmask[vec1] ? 1'bx : cell_tt[vec1];

    gate_tt_sequencer dut0 (
        .CK(CK), .RN(RN), .start(start0), .vec_o(vec0), .zn_i(zn0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
        .first_fail(ff0), .result_tt(tt0)
    );

    gate_tt_sequencer #(.N_IN(2), .SETTLE(1), .EXP_TT(4'b1110)) dut1 (
        .CK(CK), .RN(RN), .start(start1), .vec_o(vec1), .zn_i(zn1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
        .first_fail(ff1), .result_tt(tt1)
    );

    always_comb begin
        if (sel) begin
            o_vec = 32'(vec1); o_busy = 32'(busy1); o_done = 32'(done1); o_pass = 32'(pass1);
            o_err = 32'(err1); o_ff = 32'(ff1); o_tt = 32'(tt1);
        end else begin
            o_vec = 32'(vec0); o_busy = 32'(busy0); o_done = 32'(done0); o_pass = 32'(pass0);
            o_err = 32'(err0); o_ff = 32'(ff0); o_tt = 32'(tt0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic chk_reset_state();
        chk("rst_vec0", 32'(vec0), 0);  chk("rst_busy0", 32'(busy0), 0);
        chk("rst_done0", 32'(done0), 0); chk("rst_pass0", 32'(pass0), 0);
        chk("rst_err0", 32'(err0), 0);  chk("rst_ff0", 32'(ff0), 0);
        chk("rst_tt0", 32'(tt0), 0);
        chk("rst_vec1", 32'(vec1), 0);  chk("rst_done1", 32'(done1), 0);
        chk("rst_err1", 32'(err1), 0);  chk("rst_tt1", 32'(tt1), 0);
    endtask

    // One complete sweep on instance 'which', checked cycle by cycle against
    // a table-level model of the expected outcome.
    task automatic sweep(input logic which, input bit restarts);
        int n, per, nv, last, done_at, exp_err, exp_ff;
        logic [7:0] exp_tt;
        logic [7:0] table_exp;
        n         = which ? 2 : 3;
        per       = which ? 2 : 3;
        nv        = 1 << n;
        table_exp = which ? 8'h0E : 8'hFE;
        exp_err   = 0;
        exp_ff    = 0;
        exp_tt    = '0;
        last      = nv - 1;
        for (int i = 0; i < nv; i++) begin
            exp_tt[i] = xmask[i] ? 1'bx : cell_tt[i];
            if (xmask[i] || (cell_tt[i] != table_exp[i])) begin
                if (exp_err == 0) exp_ff = i;
                exp_err++;
`ifdef STOP_ON_FAIL_EN
                last = i;
                break;
`endif
            end
        end
        done_at = (last + 1) * per + 1;

        sel = which;
        @(negedge CK);
        if (which) start1 = 1'b1; else start0 = 1'b1;
        for (int k = 0; k <= done_at + 2; k++) begin
            @(negedge CK);
            start1 = 1'b0;
            start0 = restarts && (k == 4 || k == done_at - 1);
            chk("vec", o_vec, (k / per < last) ? 32'(k / per) : 32'(last));
            chk("busy", o_busy, 32'(k < (last + 1) * per));
            chk("done", o_done, 32'(k == done_at));
            if (k >= done_at) begin
                chk("err_cnt", o_err, 32'(exp_err));
                chk("pass", o_pass, 32'(exp_err == 0));
                chk("result_tt", o_tt, 32'(exp_tt));
                if (exp_err != 0) chk("first_fail", o_ff, 32'(exp_ff));
            end
        end
        start0 = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RN = 1'b0; start0 = 1'b0; start1 = 1'b0;
        cell_tt = 8'hFE; xmask = 8'h00; sel = 1'b0;
        repeat (2) @(posedge CK);
        @(negedge CK);
        chk_reset_state();
        RN = 1'b1;

        // OR3 attached: clean pass
        cell_tt = 8'hFE; xmask = 8'h00;
        sweep(1'b0, 1'b0);

        // ZN stuck at 0
        cell_tt = 8'h00;
        sweep(1'b0, 1'b0);

        // start re-pulsed while busy and while in DONE
        cell_tt = 8'hFE;
        sweep(1'b0, 1'b1);

        // Randomized cell behaviour, last run with X injection
        for (int r = 0; r < 4; r++) begin
            cell_tt = 8'($urandom);
            xmask   = (r == 3) ? 8'($urandom & $urandom) : 8'h00;
            sweep(1'b0, 1'b0);
        end
        xmask = 8'h00;

        // Reset in the middle of a sweep while vector 4 is applied
        cell_tt = 8'h00; sel = 1'b0;
        @(negedge CK); start0 = 1'b1;
        @(negedge CK); start0 = 1'b0;
        repeat (12) @(negedge CK);
        chk("mid_vec_before_rst", 32'(vec0), 4);
        RN = 1'b0;
        @(negedge CK);
        RN = 1'b1;
        chk("mid_rst_vec", 32'(vec0), 0);
        chk("mid_rst_busy", 32'(busy0), 0);
        chk("mid_rst_done", 32'(done0), 0);
        chk("mid_rst_err", 32'(err0), 0);
        chk("mid_rst_tt", 32'(tt0), 0);
        @(negedge CK);
        chk("mid_rst_idle", 32'(busy0), 0);
        cell_tt = 8'hFE;
        sweep(1'b0, 1'b0);

        // Two-input instance: OR2, then random tables
        cell_tt = 8'hFE;
        sweep(1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            cell_tt = 8'($urandom);
            xmask   = (r == 2) ? 8'($urandom & $urandom) : 8'h00;
            sweep(1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
